can_rx_frame_avalon_writer: RTL

//  Avalon-MM write master: stores each received CAN frame as a 4-word record in a ring of slots

---
 rtl/can_ctrl_pkg.sv | 26 ++
 rtl/can_rx_frame_avalon_writer.sv | 117 +++++++++++
 2 files changed

// File: rtl/can_ctrl_pkg.sv
// Shared CAN controller definitions: RX record layout in memory and writer FSM states.
package can_ctrl_pkg;
  localparam int W_ID       = 0;
  localparam int W_TS_DLC   = 1;
  localparam int W_D0       = 2;
  localparam int W_D1       = 3;
  localparam int SLOT_BYTES = 16;

  // w0 field positions
  localparam int W0_IDE_BIT = 30;
  localparam int W0_RTR_BIT = 29;
  // w1 field positions
  localparam int W1_TS_LSB  = 16;
  localparam int W1_DLC_LSB = 0;

  typedef enum logic [2:0] {IDLE, WR0, WR1, WR2, WR3, COMMIT} state_t;

  function automatic logic [31:0] pack_w0(input logic ide, input logic rtr,
                                          input logic [28:0] id);
    pack_w0 = {1'b0, ide, rtr, id};
  endfunction

  function automatic logic [31:0] pack_w1(input logic [15:0] ts, input logic [3:0] dlc);
    pack_w1 = {ts, 12'h000, dlc};
  endfunction
endpackage

// File: rtl/can_rx_frame_avalon_writer.sv
// Avalon-MM write master storing each received CAN frame as a 4-word record in a slot ring.
module can_rx_frame_avalon_writer
  import can_ctrl_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              SLOT_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  input  logic [28:0]          frame_id,
  input  logic                 frame_ide,
  input  logic                 frame_rtr,
  input  logic [3:0]           frame_dlc,
  input  logic [63:0]          frame_data,
  input  logic [15:0]          frame_ts,
  input  logic [SLOT_LOG2-1:0] rd_tail,
  output logic [SLOT_LOG2-1:0] wr_head,
  output logic [15:0]          overflow_cnt,
  output logic                 frame_irq,
  output logic [ADDR_W-1:0]    avm_address,
  output logic [3:0]           avm_byteenable,
  output logic                 avm_write,
  output logic [31:0]          avm_writedata,
  input  logic                 avm_waitrequest
);
  state_t state, state_nxt;

  logic [31:0]          hold_w1, hold_w2, hold_w3;
  logic [SLOT_LOG2-1:0] head_inc;
  logic [ADDR_W-1:0]    slot_base;
  logic                 accept, full;

  // Pointer arithmetic at SLOT_LOG2 width wraps the ring for free.
  assign head_inc  = wr_head + 1'b1;
  assign full      = (head_inc == rd_tail);
  assign slot_base = BASE_ADDR + (ADDR_W'(wr_head) << $clog2(SLOT_BYTES));
  assign accept    = frame_valid & frame_ready;

  assign avm_byteenable = 4'hF;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_ready = 1'b0;
    frame_irq   = 1'b0;
    case (state)
      IDLE: begin
        frame_ready = en;
        if (accept && !full) state_nxt = WR0;
      end
      WR0:    if (!avm_waitrequest) state_nxt = WR1;
      WR1:    if (!avm_waitrequest) state_nxt = WR2;
      WR2:    if (!avm_waitrequest) state_nxt = WR3;
      WR3:    if (!avm_waitrequest) state_nxt = COMMIT;
      COMMIT: begin
        frame_irq = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs are loaded one word ahead so each word sits on avm for its whole WRn state.
  always_ff @(posedge clk) begin
    if (reset) begin
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
      wr_head       <= '0;
      overflow_cnt  <= '0;
      hold_w1       <= '0;
      hold_w2       <= '0;
      hold_w3       <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (full) begin
            if (overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
          end else begin
            hold_w1       <= pack_w1(frame_ts, frame_dlc);
            hold_w2       <= frame_data[31:0];
            hold_w3       <= frame_data[63:32];
            avm_write     <= 1'b1;
            avm_address   <= slot_base + ADDR_W'(W_ID * 4);
            avm_writedata <= pack_w0(frame_ide, frame_rtr, frame_id);
          end
        end
        WR0: if (!avm_waitrequest) begin
          avm_address   <= slot_base + ADDR_W'(W_TS_DLC * 4);
          avm_writedata <= hold_w1;
        end
        WR1: if (!avm_waitrequest) begin
          avm_address   <= slot_base + ADDR_W'(W_D0 * 4);
          avm_writedata <= hold_w2;
        end
        WR2: if (!avm_waitrequest) begin
          avm_address   <= slot_base + ADDR_W'(W_D1 * 4);
          avm_writedata <= hold_w3;
        end
        // Head advances on the last word's acceptance so it is visible alongside frame_irq in COMMIT.
        WR3: if (!avm_waitrequest) begin
          avm_write <= 1'b0;
          wr_head   <= head_inc;
        end
        default: ;
      endcase
    end
  end
endmodule
